// File: rtl/exec_controller.sv
// rtl/exec_controller.sv - MIPS pipeline sequencer: run, single-step and halt-drain control of PC and pipeline enables
module exec_controller #(
    parameter int NBITS        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic             i_stall,
    input  logic             i_halt_fetch,
    output logic             o_pc_wr_en,
    output logic             o_pipe_en,
    output logic             o_step_done,
    output logic             o_halted,
    output logic [NBITS-1:0] o_cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] drain_cnt;
    logic [3:0] drain_cnt_nxt;
    logic       exec_state;

    assign exec_state = (state == S_RUN) || (state == S_STEP);
    assign o_pipe_en  = exec_state || (state == S_DRAIN);
    assign o_pc_wr_en = exec_state && !i_stall && !i_halt_fetch;
    assign o_halted   = (state == S_HALTED);

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        if (i_clear) begin
            state_nxt     = S_IDLE;
            drain_cnt_nxt = 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_run)
                        state_nxt = S_RUN;
                    else if (i_step)
                        state_nxt = S_STEP;
                end
                S_RUN, S_STEP: begin
                    if (i_halt_fetch) begin
                        state_nxt     = S_DRAIN;
                        drain_cnt_nxt = DRAIN_LOAD;
                    end else if (state == S_STEP) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // Counter value 0 marks the last drain cycle.
                    if (drain_cnt == 4'd0)
                        state_nxt = S_HALTED;
                    else
                        drain_cnt_nxt = drain_cnt - 4'd1;
                end
                S_HALTED: state_nxt = S_HALTED;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= S_IDLE;
            drain_cnt   <= 4'd0;
            o_step_done <= 1'b0;
            o_cycle_cnt <= '0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            o_step_done <= (state == S_STEP) && !i_clear;
            if (i_clear)
                o_cycle_cnt <= '0;
            else if (o_pipe_en && (o_cycle_cnt != '1))
                o_cycle_cnt <= o_cycle_cnt + NBITS'(1);
        end
    end

endmodule

// File: tb/tb_exec_controller.sv
// tb/tb_exec_controller.sv - randomized self-checking bench for exec_controller against a mode-level model
module tb_exec_controller;

    localparam int DRAIN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0, step = 1'b0, clr = 1'b0, stall = 1'b0, hf = 1'b0;
    logic        pc_wr_en, pipe_en, step_done, halted;
    logic [31:0] cycle_cnt;
    logic        s_pc_wr_en, s_pipe_en, s_step_done, s_halted;
    logic [3:0]  s_cycle_cnt;
    logic [31:0] tb_pc;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;

    // Model: which activity the controller is in, and how many drain cycles remain.
    bit     m_run, m_step, m_halted, m_done;
    int     m_drain;
    longint m_cnt, m_pc;

    always #5 clk = ~clk;

    exec_controller #(.NBITS(32), .DRAIN_CYCLES(DRAIN)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_step(step), .i_clear(clr),
        .i_stall(stall), .i_halt_fetch(hf),
        .o_pc_wr_en(pc_wr_en), .o_pipe_en(pipe_en), .o_step_done(step_done),
        .o_halted(halted), .o_cycle_cnt(cycle_cnt)
    );

    exec_controller #(.NBITS(4), .DRAIN_CYCLES(DRAIN)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_step(step), .i_clear(clr),
        .i_stall(stall), .i_halt_fetch(hf),
        .o_pc_wr_en(s_pc_wr_en), .o_pipe_en(s_pipe_en), .o_step_done(s_step_done),
        .o_halted(s_halted), .o_cycle_cnt(s_cycle_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tb_pc <= 32'd0;
        else if (pc_wr_en)
            tb_pc <= tb_pc + 32'd4;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit e_pipe();
        return m_run || m_step || (m_drain > 0);
    endfunction

    function automatic bit e_pcwr();
        return (m_run || m_step) && !stall && !hf;
    endfunction

    task automatic model_reset();
        m_run = 0; m_step = 0; m_halted = 0; m_done = 0;
        m_drain = 0; m_cnt = 0; m_pc = 0;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit c, input bit h);
        bit was_step;
        if (e_pcwr())
            m_pc += 4;
        if (c) begin
            m_run = 0; m_step = 0; m_halted = 0; m_drain = 0;
            m_done = 0; m_cnt = 0;
            return;
        end
        was_step = m_step;
        if (e_pipe())
            m_cnt++;
        if (m_halted) begin
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0)
                m_halted = 1;
        end else if (m_run || m_step) begin
            if (h) begin
                m_drain = DRAIN; m_run = 0; m_step = 0;
            end else begin
                m_step = 0;
            end
        end else if (r) begin
            m_run = 1;
        end else if (s) begin
            m_step = 1;
        end
        m_done = was_step;
    endtask

    task automatic tick(input bit r, input bit s, input bit c, input bit st, input bit h);
        run = r; step = s; clr = c; stall = st; hf = h;
        @(negedge clk);
        check("pipe_en", pipe_en, e_pipe());
        check("pc_wr_en", pc_wr_en, e_pcwr());
        check("halted", halted, m_halted);
        check("step_done", step_done, m_done);
        check("cycle_cnt", cycle_cnt, m_cnt);
        check("sat_cnt", s_cycle_cnt, (m_cnt > 15) ? 15 : m_cnt);
        check("pc", tb_pc, m_pc);
        if (step_done)
            n_done++;
        @(posedge clk);
        model_edge(r, s, c, h);
        #1;
        run = 0; step = 0; clr = 0; stall = 0; hf = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check("rst_pipe_en", pipe_en, 0);
        check("rst_pc_wr_en", pc_wr_en, 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_step_done", step_done, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        repeat (3) tick(0, 0, 0, 0, 0);
        check("idle_pc", tb_pc, 0);

        tick(1, 0, 0, 0, 0);
        repeat (5) tick(0, 0, 0, 0, 0);
        check("run_pc", tb_pc, 20);
        check("run_cnt", cycle_cnt, 5);

        repeat (2) tick(0, 0, 0, 1, 0);
        check("stall_pc", tb_pc, 20);
        check("stall_cnt", cycle_cnt, 7);
        tick(0, 0, 0, 0, 0);
        check("post_stall_pc", tb_pc, 24);

        tick(0, 0, 0, 0, 1);
        repeat (DRAIN) tick(0, 0, 0, 0, 0);
        check("halt_halted", halted, 1);
        check("halt_pipe_en", pipe_en, 0);
        check("halt_pc", tb_pc, 24);
        check("halt_cnt", cycle_cnt, 13);
        tick(1, 0, 0, 0, 0);
        check("halt_ignore_run", halted, 1);
        tick(0, 0, 1, 0, 0);
        check("clear_cnt", cycle_cnt, 0);
        check("clear_halted", halted, 0);

        n_done = 0;
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 0, 0, 0);
            repeat (3) tick(0, 0, 0, 0, 0);
        end
        check("step_pulses", n_done, 3);
        check("step_cnt", cycle_cnt, 3);
        check("step_pc", tb_pc, 36);

        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(29) == 0,
                 $urandom_range(3) == 0, $urandom_range(19) == 0);
        end

        tick(0, 0, 1, 0, 0);
        tick(1, 1, 0, 0, 0);
        check("both_pipe_en", pipe_en, 1);
        check("both_pc_wr_en", pc_wr_en, 1);
        tick(0, 0, 0, 0, 0);
        check("both_no_done", step_done, 0);

        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        check("arst_pipe_en", pipe_en, 0);
        check("arst_pc_wr_en", pc_wr_en, 0);
        check("arst_halted", halted, 0);
        check("arst_step_done", step_done, 0);
        check("arst_cnt", cycle_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
- Sequences the Program_Counter and the pipeline registers of the MIPS core.
- Supports three operating modes:
  - continuous run,
  - single-step, one pipeline cycle per request,
  - halt, where the pipeline drains after a HALT instruction is fetched.
- Combines the hazard unit's stall with the mode state to produce the PC write enable and the global pipeline enable.
- Sits between the debug/UART unit, the hazard unit and the PC.

Parameters:
- NBITS, 32: width of the cycle counter output.
- DRAIN_CYCLES, 4: pipeline cycles run after HALT is fetched so in-flight instructions retire. Legal range 1..15.

Ports:
- i_clk, in, 1: system clock, rising edge.
- i_rst, in, 1: asynchronous active-low reset.
- i_run, in, 1: one-cycle pulse; start continuous execution.
- i_step, in, 1: one-cycle pulse; execute exactly one pipeline cycle.
- i_clear, in, 1: one-cycle pulse; soft return to IDLE and clear the counter.
- i_stall, in, 1: load-use stall from the hazard unit; level input.
- i_halt_fetch, in, 1: HALT opcode present in the IF stage this cycle.
- o_pc_wr_en, out, 1: drives Program_Counter i_wr_en.
- o_pipe_en, out, 1: enable for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- o_step_done, out, 1: registered one-cycle pulse, the cycle after a STEP cycle.
- o_halted, out, 1: high while in HALTED.
- o_cycle_cnt, out, NBITS: count of cycles with o_pipe_en = 1.

Behaviour:
- Reset (i_rst = 0, asynchronous):
  - state = IDLE, drain counter = 0, o_cycle_cnt = 0, o_step_done = 0.
  - All outputs are 0 while reset is held.
- States: IDLE, RUN, STEP, DRAIN, HALTED. State is encoded in registers.
- Output decode:
  - o_pipe_en = 1 in RUN, STEP and DRAIN; 0 in IDLE and HALTED.
  - o_pc_wr_en = (state is RUN or STEP) & ~i_stall & ~i_halt_fetch. This is combinational from state and inputs, with zero latency.
  - o_halted = (state == HALTED).
- Transitions at posedge, in priority order:
  1. i_clear in any state -> IDLE; o_cycle_cnt <= 0 in the same edge; a pending o_step_done is suppressed.
  2. IDLE: i_run -> RUN; else i_step -> STEP. If both arrive in the same cycle, i_run wins.
  3. RUN: i_halt_fetch -> DRAIN, drain counter <= DRAIN_CYCLES-1. Otherwise stay in RUN. i_run and i_step are ignored.
  4. STEP: i_halt_fetch -> DRAIN, as in RUN. Otherwise -> IDLE. Either way o_step_done <= 1 on that edge.
  5. DRAIN: the PC is frozen; the counter decrements each cycle. When counter == 0 -> HALTED. i_run, i_step, i_stall and i_halt_fetch are ignored.
  6. HALTED: holds until i_clear. i_run and i_step are ignored.
- Stall during RUN or STEP:
  - The PC is not written and the pipeline stays enabled (bubble inserted).
  - A step still completes in one cycle. The bench must not expect a PC advance on a stalled step.
- o_step_done:
  - Registered; high for exactly one cycle after each STEP-state cycle; otherwise 0.
- o_cycle_cnt:
  - +1 on each edge where o_pipe_en was 1.
  - Saturates at all-ones and does not wrap.
  - Cleared by i_clear and by reset.
- DRAIN length: exactly DRAIN_CYCLES cycles with o_pipe_en = 1 and o_pc_wr_en = 0, then HALTED.
- Reset asserted mid-RUN or mid-DRAIN: outputs drop to 0 immediately, without waiting for a clock edge.

Test Plan:
- Reset, then release; hold 3 cycles with no request:
  - state IDLE, o_pc_wr_en = 0, o_pipe_en = 0, o_cycle_cnt = 0.
  - Program_Counter o_pc stays 0x00000000.
- Pulse i_run; run 5 cycles, no stall:
  - o_pc_wr_en = 1 every cycle; PC goes 0, 4, 8, 12, 16, 20.
  - o_cycle_cnt = 5.
- In RUN, hold i_stall for 2 cycles:
  - o_pc_wr_en = 0 for exactly those 2 cycles; PC holds its value.
  - o_pipe_en stays 1; o_cycle_cnt keeps incrementing.
- From IDLE, pulse i_step 3 times, 4 cycles apart:
  - PC advances by 4 per step; o_step_done pulses 3 times, each one cycle wide.
  - o_cycle_cnt = 3; state returns to IDLE between steps.
- In RUN, assert i_halt_fetch for one cycle (DRAIN_CYCLES = 4):
  - o_pc_wr_en = 0 from that cycle on; o_pipe_en = 1 for 4 more cycles.
  - o_halted = 1 on the 5th edge.
  - A subsequent i_run is ignored; i_clear returns to IDLE with o_cycle_cnt = 0.
- Assert i_rst = 0 asynchronously mid-DRAIN:
  - all outputs drop to 0 before the next clock edge.
- Pulse i_run and i_step together from IDLE:
  - state becomes RUN; no o_step_done pulse.
